// File: rtl/wave_capture_pkg.sv
// Shared encodings for the triggered waveform capture block.
// Contents: capture state encoding, trigger mode encoding.
// Optional feature macro used by wave_capture_trig: WAVE_CAPTURE_AUTOTRIG_EN.
package wave_capture_pkg;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_WAIT   = 2'b10
  } cap_state_t;

  typedef enum logic [1:0] {
    TRIG_RISING   = 2'b00,
    TRIG_FALLING  = 2'b01,
    TRIG_FREE_RUN = 2'b10,
    TRIG_RESERVED = 2'b11
  } trig_mode_t;

endpackage

// File: rtl/dffr.sv
// Team flop: D register with synchronous active-high reset and load enable.
// Ports:
//   i_clk    clock
//   i_reset  synchronous reset, loads RST_VAL
//   i_en     load enable
//   i_d      next value
//   o_q      registered value
module dffr #(
  parameter int              W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/wave_trigger_detect.sv
// Trigger detector: keeps the previous sample and flags a level crossing
// (rising/falling) or free-run for the current sample.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_sample_ready   strobe, i_sample_in valid; also loads the history register
//   i_sample_in      current signed sample
//   i_trig_mode      trigger mode (reserved code behaves as rising)
//   i_trig_level     signed threshold
//   o_hit            trigger condition for the current sample (not gated by strobe)
module wave_trigger_detect
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_sample_ready,
  input  logic [SAMPLE_W-1:0] i_sample_in,
  input  logic [1:0]          i_trig_mode,
  input  logic [SAMPLE_W-1:0] i_trig_level,
  output logic                o_hit
);

  logic [SAMPLE_W-1:0] r_prev;
  logic                w_prev_below;
  logic                w_cur_below;

  dffr #(.W(SAMPLE_W), .RST_VAL('0)) u_prev (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_sample_ready),
    .i_d     (i_sample_in),
    .o_q     (r_prev)
  );

  assign w_prev_below = $signed(r_prev)      < $signed(i_trig_level);
  assign w_cur_below  = $signed(i_sample_in) < $signed(i_trig_level);

  always_comb begin
    o_hit = 1'b0;
    case (trig_mode_t'(i_trig_mode))
      TRIG_FALLING:  o_hit = !w_prev_below && w_cur_below;
      TRIG_FREE_RUN: o_hit = 1'b1;
      default:       o_hit = w_prev_below && !w_cur_below;
    endcase
  end

endmodule

// File: rtl/wave_capture_trig.sv
// Triggered waveform capture into a double-buffered display RAM.
// Arms on a trigger, writes 2**ADDR_W decimated offset-binary samples into the
// half not owned by the display, then flips o_read_index once the display is idle.
// Optional feature: define WAVE_CAPTURE_AUTOTRIG_EN to force a trigger after
// AUTO_TRIG_SAMPLES strobes spent waiting in ARMED.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_new_sample_ready      sample strobe
//   i_new_sample_in         signed sample
//   i_trig_mode/i_trig_level trigger selection (sampled only while ARMED)
//   i_decim                 keep 1 of every i_decim+1 samples (latched at trigger)
//   i_wave_display_idle     buffer swap permitted
//   o_write_address         {~read_index, count}
//   o_write_enable          RAM write strobe
//   o_write_sample          top DISP_W bits of the sample, MSB inverted
//   o_read_index            half owned by the display
//   o_triggered             capture in progress or waiting for swap
module wave_capture_trig
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W          = 16,
  parameter int DISP_W            = 8,
  parameter int ADDR_W            = 8,
  parameter int DECIM_W           = 4,
  parameter int AUTO_TRIG_SAMPLES = 4096
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_new_sample_ready,
  input  logic [SAMPLE_W-1:0] i_new_sample_in,
  input  logic [1:0]          i_trig_mode,
  input  logic [SAMPLE_W-1:0] i_trig_level,
  input  logic [DECIM_W-1:0]  i_decim,
  input  logic                i_wave_display_idle,
  output logic [ADDR_W:0]     o_write_address,
  output logic                o_write_enable,
  output logic [DISP_W-1:0]   o_write_sample,
  output logic                o_read_index,
  output logic                o_triggered
);

  // State table
  //   state     | meaning
  //   ST_ARMED  | waiting for trigger condition on a strobe
  //   ST_ACTIVE | writing decimated samples into the inactive half
  //   ST_WAIT   | buffer full, waiting for display idle to swap halves

  if (DISP_W < 1 || DISP_W > SAMPLE_W) begin : g_chk_disp
    $error("DISP_W must be in 1..SAMPLE_W");
  end
  if (AUTO_TRIG_SAMPLES < 1) begin : g_chk_auto
    $error("AUTO_TRIG_SAMPLES must be at least 1");
  end

  localparam logic [DISP_W-1:0] MSB_FLIP = DISP_W'(1) << (DISP_W - 1);

  logic [1:0]         r_state_raw;
  cap_state_t         r_state;
  cap_state_t         w_state_nxt;
  logic [ADDR_W-1:0]  r_count,     w_count_nxt;
  logic [DECIM_W-1:0] r_dcnt,      w_dcnt_nxt;
  logic [DECIM_W-1:0] r_decim_q,   w_decim_q_nxt;
  logic               r_ri,        w_ri_nxt;
  logic               w_hit;
  logic               w_auto_hit;
  logic               w_fire;
  logic               w_we;

  assign r_state = cap_state_t'(r_state_raw);

  wave_trigger_detect #(.SAMPLE_W(SAMPLE_W)) u_trig (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_sample_ready (i_new_sample_ready),
    .i_sample_in    (i_new_sample_in),
    .i_trig_mode    (i_trig_mode),
    .i_trig_level   (i_trig_level),
    .o_hit          (w_hit)
  );

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  localparam int AUTO_W = $clog2(AUTO_TRIG_SAMPLES + 1);

  logic [AUTO_W-1:0] r_auto_cnt, w_auto_cnt_nxt;

  assign w_auto_hit = (r_auto_cnt == AUTO_W'(AUTO_TRIG_SAMPLES - 1));

  // Counts strobes seen while ARMED; any exit from ARMED restarts the window.
  always_comb begin
    w_auto_cnt_nxt = r_auto_cnt;
    if (r_state != ST_ARMED) begin
      w_auto_cnt_nxt = '0;
    end else if (i_new_sample_ready) begin
      w_auto_cnt_nxt = (w_hit || w_auto_hit) ? '0 : r_auto_cnt + AUTO_W'(1);
    end
  end

  dffr #(.W(AUTO_W), .RST_VAL('0)) u_auto_cnt (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(1'b1),
    .i_d(w_auto_cnt_nxt), .o_q(r_auto_cnt)
  );
`else
  assign w_auto_hit = 1'b0;
`endif

  assign w_fire = w_hit || w_auto_hit;
  assign w_we   = (r_state == ST_ACTIVE) && i_new_sample_ready && (r_dcnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_dcnt_nxt    = r_dcnt;
    w_decim_q_nxt = r_decim_q;
    w_ri_nxt      = r_ri;
    case (r_state)
      ST_ARMED: begin
        if (i_new_sample_ready && w_fire) begin
          w_state_nxt   = ST_ACTIVE;
          w_count_nxt   = '0;
          w_dcnt_nxt    = '0;
          w_decim_q_nxt = i_decim;
        end
      end
      ST_ACTIVE: begin
        if (i_new_sample_ready) begin
          if (r_dcnt == '0) begin
            // Count wraps to zero on the last write of the half.
            w_count_nxt = r_count + ADDR_W'(1);
            w_dcnt_nxt  = r_decim_q;
            if (r_count == '1) begin
              w_state_nxt = ST_WAIT;
            end
          end else begin
            w_dcnt_nxt = r_dcnt - DECIM_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (i_wave_display_idle) begin
          w_ri_nxt    = !r_ri;
          w_state_nxt = ST_ARMED;
        end
      end
      default: w_state_nxt = ST_ARMED;
    endcase
  end

  dffr #(.W(2), .RST_VAL(ST_ARMED)) u_state (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(1'b1),
    .i_d(w_state_nxt), .o_q(r_state_raw)
  );

  dffr #(.W(ADDR_W), .RST_VAL('0)) u_count (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(1'b1),
    .i_d(w_count_nxt), .o_q(r_count)
  );

  dffr #(.W(DECIM_W), .RST_VAL('0)) u_dcnt (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(1'b1),
    .i_d(w_dcnt_nxt), .o_q(r_dcnt)
  );

  dffr #(.W(DECIM_W), .RST_VAL('0)) u_decim_q (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(1'b1),
    .i_d(w_decim_q_nxt), .o_q(r_decim_q)
  );

  dffr #(.W(1), .RST_VAL(1'b0)) u_ri (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(1'b1),
    .i_d(w_ri_nxt), .o_q(r_ri)
  );

  assign o_write_enable  = w_we;
  assign o_write_address = {!r_ri, r_count};
  assign o_write_sample  = i_new_sample_in[SAMPLE_W-1 -: DISP_W] ^ MSB_FLIP;
  assign o_read_index    = r_ri;
  assign o_triggered     = (r_state == ST_ACTIVE) || (r_state == ST_WAIT);

endmodule

// File: tb/tb_wave_capture_trig.sv
module tb_wave_capture_trig;

  localparam int AUTO_N = 16;
  localparam int HALF   = 256;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rdy = 1'b0;
  logic signed [15:0] smp = '0;
  logic [1:0]         mode = '0;
  logic signed [15:0] lvl = '0;
  logic [3:0]         decim = '0;
  logic               idle = 1'b0;
  logic [8:0]         waddr;
  logic               we;
  logic [7:0]         wsamp;
  logic               ri;
  logic               trig;

  int n_tests = 0;
  int n_fail  = 0;

  wave_capture_trig #(
    .SAMPLE_W(16), .DISP_W(8), .ADDR_W(8), .DECIM_W(4), .AUTO_TRIG_SAMPLES(AUTO_N)
  ) dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_new_sample_ready  (rdy),
    .i_new_sample_in     (smp),
    .i_trig_mode         (mode),
    .i_trig_level        (lvl),
    .i_decim             (decim),
    .i_wave_display_idle (idle),
    .o_write_address     (waddr),
    .o_write_enable      (we),
    .o_write_sample      (wsamp),
    .o_read_index        (ri),
    .o_triggered         (trig)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 unit later.
  task automatic drive(input bit r, input bit rd, input int s, input int md,
                       input int lv, input int dc, input bit id);
    @(negedge clk);
    rst   = r;
    rdy   = rd;
    smp   = 16'(s);
    mode  = 2'(md);
    lvl   = 16'(lv);
    decim = 4'(dc);
    idle  = id;
    #1;
  endtask

  function automatic int exp_disp(input int s);
    logic [15:0] v;
    v = 16'(s);
    return int'(v[15:8] ^ 8'h80);
  endfunction

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  // n strobes in free-run capture, decim 0, expecting sequential writes from base.
  task automatic capture_run(input string tag, input int n, input int base);
    int s;
    for (int i = 0; i < n; i++) begin
      s = i * 37 - 3000;
      drive(0, 1, s, 2, 0, 0, 0);
      chk({tag, "_we"}, we, 1);
      chk({tag, "_addr"}, waddr, base + i);
      chk({tag, "_samp"}, wsamp, exp_disp(s));
    end
  endtask

  typedef struct {
    bit rst;
    bit rdy;
    int smp;
    int mode;
    int lvl;
    bit chk;
    bit e_we;
    bit e_trig;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit rd, input int s, input int md,
                              input int lv, input bit c, input bit ew, input bit et);
    vec_t v;
    v.rst = r; v.rdy = rd; v.smp = s; v.mode = md; v.lvl = lv;
    v.chk = c; v.e_we = ew; v.e_trig = et;
    return v;
  endfunction

  vec_t tbl[$];

  // Reference model state: phase 0 armed, 1 capturing, 2 waiting for swap.
  int m_ph, m_nwr, m_k, m_d, m_prev, m_auto;
  bit m_ri;

  task automatic m_reset();
    m_ph = 0; m_nwr = 0; m_k = 0; m_d = 0; m_prev = 0; m_auto = 0; m_ri = 0;
  endtask

  initial begin
    int  nw;
    bit  e_we;
    bit  hit;
    bit  r, rd, id;
    int  s, md, lv, dc;
    logic signed [15:0] t16;

    // ---------------- table-driven trigger vectors ----------------
    // falling, level 100
    tbl.push_back(mk(1, 0,   0, 1, 100, 0, 0, 0));
    tbl.push_back(mk(0, 1, 200, 1, 100, 1, 0, 0));
    tbl.push_back(mk(0, 1, 150, 1, 100, 1, 0, 0));
    tbl.push_back(mk(0, 1,  99, 1, 100, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1, 100, 1, 0, 1));
    tbl.push_back(mk(0, 1,  77, 1, 100, 1, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 100, 0, 0, 0));
    tbl.push_back(mk(0, 1,  50, 1, 100, 1, 0, 0));
    tbl.push_back(mk(0, 1, 101, 1, 100, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1, 100, 1, 0, 0));
    // falling from exactly the level
    tbl.push_back(mk(1, 0,   0, 1, 100, 0, 0, 0));
    tbl.push_back(mk(0, 1, 100, 1, 100, 1, 0, 0));
    tbl.push_back(mk(0, 1,  99, 1, 100, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1, 100, 1, 0, 1));
    // rising, level 0; mode change while capturing is ignored
    tbl.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  -5, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 1,   3, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 1, 0, 1));
    tbl.push_back(mk(0, 1,  10, 0,   0, 1, 1, 1));
    tbl.push_back(mk(0, 1, -50, 1, 100, 1, 1, 1));
    // rising onto exactly the level
    tbl.push_back(mk(1, 0,   0, 0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  -1, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 1,   0, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 1, 0, 1));
    // reserved mode acts as rising, level 10
    tbl.push_back(mk(1, 0,   0, 3,  10, 0, 0, 0));
    tbl.push_back(mk(0, 1,   5, 3,  10, 1, 0, 0));
    tbl.push_back(mk(0, 1,   3, 3,  10, 1, 0, 0));
    tbl.push_back(mk(0, 1,  20, 3,  10, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 3,  10, 1, 0, 1));
    // free-run needs a strobe
    tbl.push_back(mk(1, 0,   0, 2,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 2,   0, 1, 0, 0));
    tbl.push_back(mk(0, 1,   0, 2,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 2,   0, 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].smp, tbl[i].mode, tbl[i].lvl, 0, 0);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_we", i), we, int'(tbl[i].e_we));
        chk($sformatf("tbl%0d_trig", i), trig, int'(tbl[i].e_trig));
      end
    end

    // ---------------- rising capture of a ramp ----------------
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", waddr, 256);
    chk("rst_ri", ri, 0);
    chk("rst_trig", trig, 0);
    drive(0, 1, -5, 0, 0, 0, 0);
    drive(0, 1, 3, 0, 0, 0, 0);
    chk("ramp_trigsample_we", we, 0);
    for (int i = 0; i < HALF; i++) begin
      s = i * 128 - 16384;
      drive(0, 1, s, 0, 0, 0, 0);
      chk("ramp_we", we, 1);
      chk("ramp_addr", waddr, 256 + i);
      chk("ramp_samp", wsamp, exp_disp(s));
      chk("ramp_trig", trig, 1);
    end
    drive(0, 1, 9, 0, 0, 0, 0);
    chk("wait_we", we, 0);
    chk("wait_trig", trig, 1);
    chk("wait_ri", ri, 0);

    // ---------------- swap and second capture ----------------
    drive(0, 0, 0, 2, 0, 0, 1);
    chk("swap_ri_before", ri, 0);
    drive(0, 0, 0, 2, 0, 0, 0);
    chk("swap_ri_after", ri, 1);
    chk("swap_trig", trig, 0);
    chk("swap_addr", waddr, 0);
    drive(0, 1, 123, 2, 0, 0, 0);
    chk("cap2_trig_we", we, 0);
    capture_run("cap2", HALF, 0);
    drive(0, 0, 0, 2, 0, 0, 1);
    drive(0, 0, 0, 2, 0, 0, 0);
    chk("swap2_ri", ri, 0);
    drive(0, 1, 1, 2, 0, 0, 0);
    capture_run("cap3", HALF, 256);
    drive(0, 0, 0, 2, 0, 0, 1);
    drive(0, 0, 0, 2, 0, 0, 0);
    chk("swap3_ri", ri, 1);

    // ---------------- reset mid-capture ----------------
    drive(0, 1, 1, 2, 0, 0, 0);
    capture_run("part", 100, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5, 0, 0, 0, 0);
      chk("abort_we", we, 0);
      chk("abort_ri", ri, 0);
      chk("abort_trig", trig, 0);
      chk("abort_addr", waddr, 256);
    end

    // ---------------- decimation by 3, decim changes ignored ----------------
    do_reset();
    drive(0, 1, 0, 2, 0, 2, 0);
    nw = 0;
    for (int j = 1; j <= 3 * HALF; j++) begin
      drive(0, 1, j, 2, 0, (j > 5) ? ((j > 300) ? 7 : 0) : 2, 0);
      e_we = (j <= 3 * HALF - 2) && ((j - 1) % 3 == 0);
      chk($sformatf("decim_we_%0d", j), we, int'(e_we));
      if (we) begin
        chk("decim_addr", waddr, 256 + nw);
        nw++;
      end
    end
    chk("decim_total", nw, HALF);
    drive(0, 0, 0, 2, 0, 0, 0);
    chk("decim_wait_trig", trig, 1);

    // ---------------- flat input: auto trigger ----------------
    do_reset();
    for (int j = 1; j <= AUTO_N; j++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      chk($sformatf("flat_trig_%0d", j), trig, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    chk("auto_trig_fired", trig, 1);
`else
    chk("flat_no_trig", trig, 0);
    for (int j = 0; j < 40; j++) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("flat_no_trig_long", trig, 0);
`endif

    // ---------------- randomized run against reference model ----------------
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      r  = ($urandom_range(0, 1999) == 0);
      rd = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        t16 = 16'($urandom);
        s = int'(t16);
      end else begin
        s = int'($urandom_range(0, 80)) - 40;
      end
      md = int'($urandom_range(0, 3));
      lv = int'($urandom_range(0, 40)) - 20;
      dc = int'($urandom_range(0, 3));
      id = ($urandom_range(0, 7) == 0);
      drive(r, rd, s, md, lv, dc, id);

      e_we = (m_ph == 1) && rd && ((m_k % (m_d + 1)) == 0);
      chk("rnd_we", we, int'(e_we));
      chk("rnd_ri", ri, int'(m_ri));
      chk("rnd_trig", trig, int'(m_ph != 0));
      if (e_we) begin
        chk("rnd_addr", waddr, (m_ri ? 0 : 256) + m_nwr);
        chk("rnd_samp", wsamp, exp_disp(s));
      end

      if (r) begin
        m_reset();
      end else begin
        case (m_ph)
          0: begin
            if (rd) begin
              if (md == 2)      hit = 1;
              else if (md == 1) hit = (m_prev >= lv) && (s < lv);
              else              hit = (m_prev < lv) && (s >= lv);
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
              if (m_auto == AUTO_N - 1) hit = 1;
              m_auto = hit ? 0 : m_auto + 1;
`endif
              if (hit) begin
                m_ph = 1; m_nwr = 0; m_k = 0; m_d = dc;
              end
            end
          end
          1: begin
            m_auto = 0;
            if (rd) begin
              if (e_we) begin
                m_nwr++;
                if (m_nwr == HALF) m_ph = 2;
              end
              m_k++;
            end
          end
          default: begin
            m_auto = 0;
            if (id) begin
              m_ri = !m_ri;
              m_ph = 0;
            end
          end
        endcase
        if (rd) m_prev = s;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
